// File: rtl/audio_dac_modulator.sv
// 1-bit audio output stage: PWM, 1st/2nd-order delta-sigma or mute,
// driven from the 8-bit offset-binary filter sample stream.
module audio_dac_modulator #(
    parameter int          SAMPLE_BITS = 8,
    parameter int          INT_BITS    = 12,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    input  logic                   sample_valid,
    input  logic [1:0]             mode,
    input  logic                   dither_en,
    input  logic                   clear_overrun,
    output logic                   dac_out,
    output logic                   sample_ack,
    output logic                   overrun
);

    localparam int SW = SAMPLE_BITS;
    localparam int IW = INT_BITS;
    localparam int WW = INT_BITS + 2;

    localparam logic [SW-1:0] MID = {1'b1, {(SW-1){1'b0}}};

    localparam logic signed [WW-1:0] FB_POS = WW'(2 ** (SW - 1));
    localparam logic signed [WW-1:0] FB_NEG = WW'(-(2 ** (SW - 1)));
    localparam logic signed [WW-1:0] SAT_HI = WW'((2 ** (IW - 1)) - 1);
    localparam logic signed [WW-1:0] SAT_LO = WW'(-(2 ** (IW - 1)));

    typedef enum logic [1:0] {
        MODE_PWM  = 2'd0,
        MODE_DS1  = 2'd1,
        MODE_DS2  = 2'd2,
        MODE_MUTE = 2'd3
    } mode_t;

    // Registered state
    logic [SW-1:0]        sample_reg;
    logic [SW-1:0]        pending;
    logic [SW-1:0]        active;
    logic [SW-1:0]        pwm_cnt;
    logic                 pend_full;
    logic [SW-1:0]        acc1;
    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic                 ds_fb;
    mode_t                mode_q;
    logic [15:0]          lfsr;

    // Combinational helpers
    mode_t                mode_in;
    logic                 mode_chg;
    logic                 is_pwm;
    logic                 pwm_run;
    logic                 dith;
    logic                 lfsr_bit;

    logic [SW-1:0]        pwm_cnt_next;
    logic                 pwm_wrap;
    logic [SW-1:0]        active_next;
    logic                 pwm_bit;
    logic                 consume;
    logic                 held;
    logic                 ovr_set;

    logic [SW:0]          sum1;

    logic signed [SW-1:0] x_s;
    logic signed [WW-1:0] x_w;
    logic signed [WW-1:0] fb_w;
    logic signed [WW-1:0] dith_w;
    logic signed [WW-1:0] i1_w;
    logic signed [WW-1:0] i2_w;
    logic signed [WW-1:0] sum_i1;
    logic signed [IW-1:0] i1_next;
    logic signed [WW-1:0] i1n_w;
    logic signed [WW-1:0] sum_i2;
    logic signed [IW-1:0] i2_next;
    logic                 fb_next;

    logic                 dac_next;

    function automatic logic signed [IW-1:0] sat(
        input logic signed [WW-1:0] v
    );
        logic signed [WW-1:0] r;
        if (v > SAT_HI) begin
            r = SAT_HI;
        end else if (v < SAT_LO) begin
            r = SAT_LO;
        end else begin
            r = v;
        end
        return r[IW-1:0];
    endfunction

    assign mode_in  = mode_t'(mode);
    assign mode_chg = (mode_in != mode_q);
    assign is_pwm   = (mode_in == MODE_PWM);
    assign pwm_run  = is_pwm && !mode_chg;
    assign dith     = dither_en & lfsr[0];
    assign lfsr_bit = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // PWM: the period boundary is the edge where the counter sits at all-ones.
    assign pwm_cnt_next = pwm_cnt + 1'b1;
    assign pwm_wrap     = (pwm_cnt == {SW{1'b1}});
    assign active_next  = pwm_wrap ? pending : active;
    assign pwm_bit      = (pwm_cnt_next < active_next);

    // A sample is "held" while it sits in (or is landing in) pending
    // and has not yet been copied into active.
    assign consume = pwm_run & pwm_wrap;
    assign held    = sample_ack | (pend_full & ~consume);
    assign ovr_set = sample_valid & is_pwm & held;

    // DS1: the carry out of the 8-bit accumulator is the output bit.
    assign sum1 = {1'b0, acc1} + {1'b0, sample_reg} + {{SW{1'b0}}, dith};

    // DS2: offset binary to two's complement, feedback is +/- half scale.
    assign x_s     = {~sample_reg[SW-1], sample_reg[SW-2:0]};
    assign x_w     = {{(WW-SW){x_s[SW-1]}}, x_s};
    assign fb_w    = ds_fb ? FB_POS : FB_NEG;
    assign dith_w  = {{(WW-1){1'b0}}, dith};
    assign i1_w    = {{2{i1[IW-1]}}, i1};
    assign i2_w    = {{2{i2[IW-1]}}, i2};
    assign sum_i1  = i1_w + x_w - fb_w + dith_w;
    assign i1_next = sat(sum_i1);
    assign i1n_w   = {{2{i1_next[IW-1]}}, i1_next};
    assign sum_i2  = i2_w + i1n_w - fb_w;
    assign i2_next = sat(sum_i2);
    assign fb_next = ~i2_next[IW-1];

    // Select the next output bit from the running modulator.
    always_comb begin
        dac_next = 1'b0;
        if (!mode_chg) begin
            unique case (mode_in)
                MODE_PWM:  dac_next = pwm_bit;
                MODE_DS1:  dac_next = sum1[SW];
                MODE_DS2:  dac_next = fb_next;
                MODE_MUTE: dac_next = 1'b0;
                default:   dac_next = 1'b0;
            endcase
        end
    end

    // Dither LFSR free-runs in every mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_bit};
        end
    end

    // Sample capture, acknowledge, pending buffer and mode register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_reg <= MID;
            sample_ack <= 1'b0;
            pending    <= MID;
            mode_q     <= MODE_PWM;
        end else begin
            sample_ack <= sample_valid;
            if (sample_valid) begin
                sample_reg <= sample_in;
            end
            if (sample_ack) begin
                pending <= sample_reg;
            end
            mode_q <= mode_in;
        end
    end

    // Overrun tracking: set beats clear, and only PWM can set it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_full <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pend_full <= is_pwm ? held : 1'b0;
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // PWM counter and double-buffered duty register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            active  <= MID;
        end else if (pwm_run) begin
            pwm_cnt <= pwm_cnt_next;
            active  <= active_next;
        end else begin
            pwm_cnt <= '0;
        end
    end

    // First-order accumulator; wraps by design.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc1 <= '0;
        end else if (!mode_chg && mode_in == MODE_DS1) begin
            acc1 <= sum1[SW-1:0];
        end else begin
            acc1 <= '0;
        end
    end

    // Second-order saturating integrators and comparator feedback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1    <= '0;
            i2    <= '0;
            ds_fb <= 1'b0;
        end else if (!mode_chg && mode_in == MODE_DS2) begin
            i1    <= i1_next;
            i2    <= i2_next;
            ds_fb <= fb_next;
        end else begin
            i1    <= '0;
            i2    <= '0;
            ds_fb <= 1'b0;
        end
    end

    // Registered output pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_out <= 1'b0;
        end else begin
            dac_out <= dac_next;
        end
    end

endmodule

// File: tb/tb_audio_dac_modulator.sv
// Directed bench for audio_dac_modulator: PWM duty, overrun,
// DS1/DS2 densities, mode switching, mute and async reset.
module tb_audio_dac_modulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic [1:0] mode;
    logic       dither_en;
    logic       clear_overrun;
    logic       dac_out;
    logic       sample_ack;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ones;
    int acks;
    int sat_seen;

    audio_dac_modulator dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .mode          (mode),
        .dither_en     (dither_en),
        .clear_overrun (clear_overrun),
        .dac_out       (dac_out),
        .sample_ack    (sample_ack),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs,
                               input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d",
                   tag, obs, lo, hi);
        end
    endtask

    task automatic strobe(input logic [7:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic count(input int n, output int o, output int a);
        o = 0;
        a = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            o += int'(dac_out);
            a += int'(sample_ack);
        end
    endtask

    initial begin
        int exp_seq [8];
        exp_seq = '{1, 1, 0, 1, 0, 0, 1, 1};

        reset         = 1'b1;
        sample_in     = 8'h00;
        sample_valid  = 1'b0;
        mode          = 2'd0;
        dither_en     = 1'b0;
        clear_overrun = 1'b0;
        tick();
        tick();
        check("rst_dac", int'(dac_out), 0);
        check("rst_ack", int'(sample_ack), 0);
        check("rst_ovr", int'(overrun), 0);
        reset = 1'b0;
        cyc   = 0;

        // PWM duty for held samples
        strobe(8'h40);
        idle(520);
        count(256, ones, acks);
        check("pwm_40", ones, 64);
        strobe(8'h00);
        idle(520);
        count(256, ones, acks);
        check("pwm_00", ones, 0);
        strobe(8'hFF);
        idle(520);
        count(256, ones, acks);
        check("pwm_ff", ones, 255);
        check("pwm_no_ovr", int'(overrun), 0);

        // Async reset while output is high
        tick();
        if (dac_out !== 1'b1) tick();
        check("pre_rst_dac", int'(dac_out), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_dac", int'(dac_out), 0);
        check("async_rst_ovr", int'(overrun), 0);
        check("async_rst_cnt", int'(dut.pwm_cnt), 0);
        check("async_rst_act", int'(dut.active), 128);
        check("async_rst_pend", int'(dut.pending), 128);
        check("async_rst_lfsr", int'(dut.lfsr), 16'hACE1);
        tick();
        reset = 1'b0;
        cyc   = 0;
        count(256, ones, acks);
        check("pwm_reset_mid", ones, 128);

        // Overrun: two strobes within one period
        strobe(8'h10);
        check("ack_pulse", int'(sample_ack), 1);
        tick();
        check("ack_drop", int'(sample_ack), 0);
        tick();
        strobe(8'h20);
        check("ovr_set", int'(overrun), 1);
        while (cyc < 511) tick();
        count(256, ones, acks);
        check("pwm_after_ovr", ones, 32);
        check("ovr_sticky", int'(overrun), 1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("ovr_clear", int'(overrun), 0);
        strobe(8'h30);
        tick();
        clear_overrun = 1'b1;
        strobe(8'h30);
        clear_overrun = 1'b0;
        check("ovr_set_prio", int'(overrun), 1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("ovr_clear2", int'(overrun), 0);

        // DS1, no dither, 0xC0 -> 3/4 density
        mode = 2'd1;
        tick();
        check("ds1_chg_dac", int'(dac_out), 0);
        strobe(8'hC0);
        tick();
        ones = 0;
        acks = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i % 200 == 50) begin
                sample_in    = 8'hC0;
                sample_valid = 1'b1;
            end
            tick();
            sample_valid = 1'b0;
            ones += int'(dac_out);
            acks += int'(sample_ack);
        end
        check("ds1_c0_ones", ones, 768);
        check("ds1_acks", acks, 5);
        check("ds1_no_ovr", int'(overrun), 0);

        // Mute holds output low, still acks
        mode = 2'd3;
        tick();
        check("mute_chg_dac", int'(dac_out), 0);
        strobe(8'hFF);
        check("mute_ack", int'(sample_ack), 1);
        count(50, ones, acks);
        check("mute_ones", ones, 0);

        // DS1 full scale with and without dither
        dither_en = 1'b1;
        mode      = 2'd1;
        tick();
        check("ds1d_chg_dac", int'(dac_out), 0);
        count(300, ones, acks);
        check("ds1_ff_dith", ones, 299);
        mode = 2'd3;
        tick();
        dither_en = 1'b0;
        mode      = 2'd1;
        tick();
        count(300, ones, acks);
        check("ds1_ff_nodith", ones, 298);

        // Switch DS1 -> DS2 mid-stream at mid-scale
        strobe(8'h80);
        tick();
        mode = 2'd2;
        tick();
        check("ds2_chg_dac", int'(dac_out), 0);
        check("ds2_chg_i1", int'(dut.i1), 0);
        check("ds2_chg_i2", int'(dut.i2), 0);
        ones     = 0;
        sat_seen = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            if (i < 8) check("ds2_seq", int'(dac_out), exp_seq[i]);
            ones += int'(dac_out);
            if (int'(dut.i1) >= 2047 || int'(dut.i1) <= -2048 ||
                int'(dut.i2) >= 2047 || int'(dut.i2) <= -2048) begin
                sat_seen = 1;
            end
        end
        check_range("ds2_80_ones", ones, 2044, 2052);
        check("ds2_80_nosat", sat_seen, 0);

        // DS2 near full scale
        strobe(8'hFF);
        count(4096, ones, acks);
        check_range("ds2_ff_ones", ones, 3968, 4095);

        // Back to mute
        mode = 2'd3;
        tick();
        check("mute2_chg_dac", int'(dac_out), 0);
        count(100, ones, acks);
        check("mute2_ones", ones, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
